// File: rtl/drap_pkg.sv
// Shared constants and types for the DRAP fetch stage.
package drap_pkg;

  localparam int unsigned B_DEF  = 32;
  localparam int unsigned W_DEF  = 7;
  localparam int unsigned CW_DEF = 16;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/drap_ifetch_if.sv
// Instruction-memory address/data bus plus the IF/ID register outputs.
interface drap_ifetch_if #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 7
);

  logic [W-1:0] imem_addr;
  logic [B-1:0] imem_data;
  logic [B-1:0] instr;
  logic [W-1:0] pc_out;
  logic [W-1:0] pc_plus1;
  logic         valid;

  // Fetch stage side.
  modport master (
    output imem_addr,
    input  imem_data,
    output instr,
    output pc_out,
    output pc_plus1,
    output valid
  );

  // Memory / decode side.
  modport slave (
    input  imem_addr,
    output imem_data,
    input  instr,
    input  pc_out,
    input  pc_plus1,
    input  valid
  );

endinterface

// File: rtl/drap_pc_next.sv
// Combinational next-PC select: halt hold, jump, branch, stall, flush, halt word, pc+1.
module drap_pc_next import drap_pkg::*; #(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] pc,
  input  logic         in_halt,
  input  logic         jump,
  input  logic [W-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  input  logic         stall,
  input  logic         flush,
  input  logic         halt_word,
  output logic [W-1:0] pc_next,
  output logic [W-1:0] pc_inc
);

  // Natural W-bit truncation gives the wrap from 2**W-1 to 0.
  assign pc_inc = pc + W'(1);

  // Priority select; a halt word only matters in a plain fetch cycle.
  always_comb begin
    pc_next = pc_inc;
    if (in_halt)           pc_next = pc;
    else if (jump)         pc_next = jump_target;
    else if (branch_taken) pc_next = branch_target;
    else if (stall)        pc_next = pc;
    else if (flush)        pc_next = pc_inc;
    else if (halt_word)    pc_next = pc;
  end

endmodule

// File: rtl/drap_ifetch.sv
// DRAP instruction fetch stage: PC, IF/ID register, RUN/HALT FSM, fetch counter.
module drap_ifetch import drap_pkg::*; #(
  parameter int unsigned B  = B_DEF,
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  logic [W-1:0]  branch_target,
  input  logic          jump,
  input  logic [W-1:0]  jump_target,
  drap_ifetch_if.master bus,
  output logic          halted,
  output logic [CW-1:0] fetch_count
);

  fetch_state_e  state_q, state_d;
  logic [W-1:0]  pc_q, pc_d, pc_inc;
  logic [B-1:0]  instr_q, instr_d;
  logic [W-1:0]  pc_out_q, pc_out_d;
  logic [W-1:0]  pc_plus1_q, pc_plus1_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_word;

  assign halt_word = (bus.imem_data == B'(HALT_WORD));

  drap_pc_next #(
    .W (W)
  ) u_pc_next (
    .pc            (pc_q),
    .in_halt       (state_q == StHalt),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .halt_word     (halt_word),
    .pc_next       (pc_d),
    .pc_inc        (pc_inc)
  );

  // FSM next state and IF/ID / counter next values.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    count_d    = count_q;
    unique case (state_q)
      StRun: begin
        if (jump || branch_taken || (!stall && flush)) begin
          // Bubble: pc_out/pc_plus1 keep their old values.
          instr_d = B'(NOP_WORD);
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d    = bus.imem_data;
          pc_out_d   = pc_q;
          pc_plus1_d = pc_inc;
          valid_d    = 1'b1;
          if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
          if (halt_word) state_d = StHalt;
        end
      end
      StHalt: begin
        instr_d = B'(NOP_WORD);
        valid_d = 1'b0;
      end
      default: state_d = StRun;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= '0;
      instr_q    <= B'(NOP_WORD);
      pc_out_q   <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.pc_plus1  = pc_plus1_q;
  assign bus.valid     = valid_q;
  assign halted        = (state_q == StHalt);
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_drap_ifetch.sv
// Directed self-checking bench for drap_ifetch (CW=4 to reach counter saturation quickly).
module tb_drap_ifetch;

  localparam int unsigned B  = 32;
  localparam int unsigned W  = 7;
  localparam int unsigned CW = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset, stall, flush, branch_taken, jump;
  logic [W-1:0]  branch_target, jump_target;
  logic          halted;
  logic [CW-1:0] fetch_count;
  logic [31:0]   mem [0:127];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  drap_ifetch_if #(.B(B), .W(W)) dbus ();

  assign dbus.imem_data = mem[dbus.imem_addr];

  drap_ifetch #(
    .B  (B),
    .W  (W),
    .CW (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .bus           (dbus.master),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full IF/ID register plus the address port.
  task automatic check_ifid(input string tag, input logic [31:0] e_instr, input int e_pc_out,
                            input int e_plus1, input logic e_valid, input int e_addr);
    check({tag, ".instr"}, dbus.instr, e_instr);
    check({tag, ".pc_out"}, 32'(dbus.pc_out), 32'(e_pc_out));
    check({tag, ".pc_plus1"}, 32'(dbus.pc_plus1), 32'(e_plus1));
    check({tag, ".valid"}, 32'(dbus.valid), 32'(e_valid));
    check({tag, ".imem_addr"}, 32'(dbus.imem_addr), 32'(e_addr));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i + 100);
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;

    // Reset state.
    tick(); tick();
    check_ifid("reset", 32'h0, 0, 0, 1'b0, 0);
    check("reset.halted", 32'(halted), 32'h0);
    check("reset.count", 32'(fetch_count), 32'h0);

    // Free run: edge k loads word k.
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_ifid($sformatf("run%0d", k), 32'(k + 100), k, k + 1, 1'b1, k + 1);
      check($sformatf("run%0d.count", k), 32'(fetch_count), 32'(k + 1));
    end

    // Stall three cycles at pc=5.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid($sformatf("stall%0d", k), 32'd104, 4, 5, 1'b1, 5);
    end
    stall = 1'b0;
    tick();
    check_ifid("unstall", 32'd105, 5, 6, 1'b1, 6);
    check("unstall.count", 32'(fetch_count), 32'd6);

    // Jump beats branch, redirect beats stall.
    jump = 1'b1; jump_target = 7'd40;
    branch_taken = 1'b1; branch_target = 7'd20;
    stall = 1'b1;
    tick();
    check_ifid("redir", 32'h0, 5, 6, 1'b0, 40);
    check("redir.count", 32'(fetch_count), 32'd6);
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    tick();
    check_ifid("jmp40", 32'd140, 40, 41, 1'b1, 41);

    // Wrap from 127 to 0.
    branch_taken = 1'b1; branch_target = 7'd127;
    tick();
    check_ifid("br127", 32'h0, 40, 41, 1'b0, 127);
    branch_taken = 1'b0;
    tick();
    check_ifid("pc127", 32'd227, 127, 0, 1'b1, 0);
    tick();
    check_ifid("pc0", 32'd100, 0, 1, 1'b1, 1);
    check("pc0.count", 32'(fetch_count), 32'd9);

    // HALT word in the flush slot is ignored.
    mem[1] = HALT;
    flush = 1'b1;
    tick();
    check_ifid("flush", 32'h0, 0, 1, 1'b0, 2);
    check("flush.halted", 32'(halted), 32'h0);
    check("flush.count", 32'(fetch_count), 32'd9);
    flush = 1'b0;
    mem[1] = 32'd101;

    // Counter climbs 10..15 then saturates.
    for (int k = 2; k <= 8; k++) begin
      tick();
      check_ifid($sformatf("sat%0d", k), 32'(k + 100), k, k + 1, 1'b1, k + 1);
      check($sformatf("sat%0d.count", k), 32'(fetch_count), (k + 8 > 15) ? 32'd15 : 32'(k + 8));
    end

    // Halt at address 3.
    reset = 1'b1;
    mem[3] = HALT;
    tick();
    check("rst2.count", 32'(fetch_count), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_ifid("pre_halt", 32'd102, 2, 3, 1'b1, 3);
    tick();
    check_ifid("halt_word", HALT, 3, 4, 1'b1, 3);
    check("halt_word.halted", 32'(halted), 32'h1);
    check("halt_word.count", 32'(fetch_count), 32'd4);
    tick();
    check_ifid("halted", 32'h0, 3, 4, 1'b0, 3);
    check("halted.halted", 32'(halted), 32'h1);

    // Jump ignored while halted.
    jump = 1'b1; jump_target = 7'd40;
    tick();
    check_ifid("halt_jmp", 32'h0, 3, 4, 1'b0, 3);
    check("halt_jmp.halted", 32'(halted), 32'h1);
    check("halt_jmp.count", 32'(fetch_count), 32'd4);
    jump = 1'b0;

    // Reset leaves HALT.
    reset = 1'b1;
    tick();
    check_ifid("unhalt", 32'h0, 0, 0, 1'b0, 0);
    check("unhalt.halted", 32'(halted), 32'h0);
    reset = 1'b0;
    tick();
    check_ifid("after", 32'd100, 0, 1, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
